// File: rtl/pipo_ctrl_pkg.sv
// Shared state encoding and index helper for the pipo load arbiter.
package pipo_ctrl_pkg;

   localparam int MAX_REQ   = 16;
   localparam int MAX_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(
      input logic [MAX_REQ-1:0] oh
   );
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pipo_load_arbiter_rr_select.sv
// Rotating-priority winner search starting at rr_ptr.
module rr_select
   import pipo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_grant
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_req;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
      assign upper_mask[i] = (ID_W'(i) >= rr_ptr);
   end

   assign upper_req = req_valid & upper_mask;

   function automatic logic [NUM_REQ-1:0] lowest(
      input logic [NUM_REQ-1:0] v
   );
      return v & (~v + NUM_REQ'(1));
   endfunction

   // Requests at or above the pointer win; otherwise wrap to the bottom.
   always_comb begin
      grant_onehot = '0;
      if (|upper_req) grant_onehot = lowest(upper_req);
      else            grant_onehot = lowest(req_valid);
   end

   assign any_grant = |req_valid;
   assign grant_idx = ID_W'(onehot_to_idx(MAX_REQ'(grant_onehot)));

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin sharing of one external pipo register between requesters.
module pipo_load_arbiter
   import pipo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          pipo_load,
   output logic [DATA_WIDTH-1:0]         pipo_data,
   output logic                          out_valid,
   output logic [ID_W-1:0]               owner_id,
   output logic                          busy
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                  pipo_load_q, pipo_load_d;
   logic [DATA_WIDTH-1:0] pipo_data_q, pipo_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [ID_W-1:0]       owner_id_q, owner_id_d;

   logic [NUM_REQ-1:0]    grant_onehot;
   logic [ID_W-1:0]       grant_idx;
   logic                  any_grant;
   logic [DATA_WIDTH-1:0] grant_word;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_select (
      .req_valid    (req_valid),
      .rr_ptr       (rr_ptr_q),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any_grant    (any_grant)
   );

   always_comb begin
      grant_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_onehot[i]) begin
            grant_word = grant_word | req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      hold_cnt_d  = hold_cnt_q;
      pipo_load_d = 1'b0;
      pipo_data_d = pipo_data_q;
      out_valid_d = out_valid_q;
      owner_id_d  = owner_id_q;
      unique case (state_q)
         IDLE: begin
            if (any_grant) begin
               pipo_load_d = 1'b1;
               pipo_data_d = grant_word;
               owner_id_d  = grant_idx;
               state_d     = LOAD;
               if (grant_idx == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
               else rr_ptr_d = grant_idx + ID_W'(1);
            end
         end
         LOAD: begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            hold_cnt_d  = CNT_W'(HOLD_CYCLES - 1);
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         hold_cnt_q  <= '0;
         pipo_load_q <= 1'b0;
         pipo_data_q <= '0;
         out_valid_q <= 1'b0;
         owner_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         pipo_load_q <= pipo_load_d;
         pipo_data_q <= pipo_data_d;
         out_valid_q <= out_valid_d;
         owner_id_q  <= owner_id_d;
      end
   end

   // Ready is suppressed under reset so no handshake can complete then.
   assign req_ready = (state_q == IDLE && !reset) ? grant_onehot : '0;
   assign pipo_load = pipo_load_q;
   assign pipo_data = pipo_data_q;
   assign out_valid = out_valid_q;
   assign owner_id  = owner_id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
- Round-robin controller that shares one pipo parallel-in/parallel-out register between NUM_REQ requesters.
- Accepts one word per grant over a valid/ready handshake and drives the register's load and parallel_in.
- Reports owner ID and a result-valid window while the loaded word sits on the register output.
- Sits between request sources and a single external pipo instance.

Parameters:
- DATA_WIDTH, 16, width of each request word and of the pipo register.
- NUM_REQ, 4, number of requesters; legal range 1..16; need not be a power of two.
- HOLD_CYCLES, 2, cycles the loaded word is owned (out_valid high) before the next grant; legal range >= 1.
- ID_W, $clog2(NUM_REQ) (minimum 1), width of owner_id.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request; must be held until its ready is seen.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero, combinational; handshake completes when req_valid[i] and req_ready[i] are both high at an edge.
- pipo_load  output  1  registered load strobe to the pipo register.
- pipo_data  output  DATA_WIDTH  registered word to pipo parallel_in.
- out_valid  output  1  pipo parallel_out holds the granted word.
- owner_id  output  ID_W  index of the requester owning the current word.
- busy  output  1  high in LOAD and HOLD.

Behaviour:
- States: IDLE, LOAD, HOLD.
- Reset (synchronous, dominates all other inputs):
  - state=IDLE, rr_ptr=0, hold_cnt=0.
  - pipo_load=0, pipo_data=0, out_valid=0, owner_id=0, busy=0.
  - req_ready is 0 during the reset cycle.
- IDLE:
  - Winner w is the first set bit of req_valid scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = onehot(w) when any req_valid is set, else 0.
  - At the edge: pipo_data <= word w, pipo_load <= 1, owner_id <= w, rr_ptr <= (w+1) mod NUM_REQ (explicit wrap from NUM_REQ-1 to 0), go to LOAD.
  - If no req_valid is set, stay in IDLE with all outputs unchanged except pipo_load=0.
- LOAD (one cycle):
  - pipo_load=1 and busy=1; the pipo register captures at the end of this cycle.
  - Next state HOLD; pipo_load <= 0, out_valid <= 1, hold_cnt <= HOLD_CYCLES-1.
- HOLD:
  - out_valid=1, busy=1, req_ready=0.
  - Decrement hold_cnt each cycle; when hold_cnt==0, go to IDLE with out_valid <= 0.
- Latency, with handshake in cycle T:
  - pipo_load high in T+1.
  - out_valid high in T+2 .. T+1+HOLD_CYCLES.
  - Earliest next handshake in T+2+HOLD_CYCLES.
  - Minimum grant spacing is 2+HOLD_CYCLES cycles.
- Fairness: with all requesters continuously valid, grants rotate strictly 0,1,...,NUM_REQ-1,0.
- Requests that rise during LOAD/HOLD see req_ready=0 and are arbitrated in the next IDLE cycle.
- A req_valid that drops in IDLE before an edge is not granted; rr_ptr is unchanged.
- pipo_data and owner_id hold their last values through IDLE until the next grant.
- Reset mid-LOAD or mid-HOLD aborts the operation: the next cycle shows reset values, and rr_ptr returns to 0.
- NUM_REQ=1: the arbiter degenerates to a single-requester sequencer and rr_ptr stays 0.

Decomposition:
- Package pipo_ctrl_pkg:
  - state_t enum {IDLE, LOAD, HOLD}.
  - Helper function onehot_to_idx.
- Sub-module rr_select:
  - Combinational rotate-priority search.
  - Inputs: req_valid, rr_ptr. Outputs: grant_onehot, grant_idx, any_grant.
  - Instantiated once.
- FSM, hold counter and output registers live in pipo_load_arbiter.

Test Plan (DATA_WIDTH=16, NUM_REQ=4, HOLD_CYCLES=2; external pipo instantiated in the bench):
1. Assert reset 2 cycles with req_valid=4'b1111 -> req_ready=0, pipo_load=0, out_valid=0, busy=0, owner_id=0, pipo_data=16'h0000 throughout.
2. req_valid=4'b0100, word2=16'hA5A5 -> req_ready=4'b0100 in cycle T; pipo_load=1 with pipo_data=16'hA5A5 in T+1; out_valid=1, owner_id=2 and pipo parallel_out=16'hA5A5 in T+2 and T+3; idle in T+4.
3. All valid continuously, words 16'h1111/2222/3333/4444 -> grants 0,1,2,3,0 spaced 4 cycles apart; parallel_out sequence 1111,2222,3333,4444,1111.
4. Pointer wrap: after a grant to 3 (rr_ptr=0), req_valid=4'b1010 -> grant 1 first, then 3; then req_valid=4'b1001 -> grant 0 first, then 3.
5. Requester 0 raises valid in the first HOLD cycle of requester 1's grant -> req_ready[0] stays 0 until the next IDLE, then is granted.
6. Reset asserted in the second HOLD cycle -> the next cycle has out_valid=0 and busy=0; after release, req_valid=4'b1111 grants 0 (rr_ptr reset).
